// File: rtl/r4_pkg.sv
// rtl/r4_pkg.sv - shared states, constants and sample type for the radix-4 butterfly sequencer
package r4_pkg;

  localparam int R4_N       = 4;
  localparam int SEL_EN_BIT = 2;
  localparam int R4_W       = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    CAPTURE,
    DRAIN
  } r4_state_t;

  typedef struct packed {
    logic [R4_W-1:0] re;
    logic [R4_W-1:0] im;
  } cplx_t;

endpackage

// File: rtl/r4_result_buf.sv
// rtl/r4_result_buf.sv - four-entry complex result store, one write port and one read port
module r4_result_buf
  import r4_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [1:0]   wr_idx,
  input  logic [W-1:0] wr_re,
  input  logic [W-1:0] wr_im,
  input  logic [1:0]   rd_idx,
  output logic [W-1:0] rd_re,
  output logic [W-1:0] rd_im
);

  typedef struct packed {
    logic [W-1:0] re;
    logic [W-1:0] im;
  } cplx_w_t;

  cplx_w_t mem [R4_N];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < R4_N; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_idx] <= {wr_re, wr_im};
    end
  end

  assign rd_re = mem[rd_idx].re;
  assign rd_im = mem[rd_idx].im;

endmodule

// File: rtl/r4_butter_seq.sv
// rtl/r4_butter_seq.sv - loads four samples, steps the butterfly select lines, returns four results
module r4_butter_seq #(
  parameter int W      = 4,
  parameter int SETTLE = 1
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  input  logic         start,
  input  logic         abort,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_re,
  input  logic [W-1:0] in_im,
  output logic [W-1:0] xr0,
  output logic [W-1:0] xr1,
  output logic [W-1:0] xr2,
  output logic [W-1:0] xr3,
  output logic [W-1:0] xi0,
  output logic [W-1:0] xi1,
  output logic [W-1:0] xi2,
  output logic [W-1:0] xi3,
  output logic [2:0]   sel,
  input  logic [W-1:0] Xr,
  input  logic [W-1:0] Xi,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_re,
  output logic [W-1:0] out_im,
  output logic [1:0]   out_idx,
  output logic         busy,
  output logic         done
);

  // The SETTLE parameter shadows the state name, so that state is always package-qualified.
  import r4_pkg::r4_state_t;
  import r4_pkg::IDLE;
  import r4_pkg::LOAD;
  import r4_pkg::CAPTURE;
  import r4_pkg::DRAIN;
  import r4_pkg::R4_N;
  import r4_pkg::SEL_EN_BIT;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE);
  localparam logic [1:0] LAST_IDX  = 2'(R4_N - 1);

  typedef struct packed {
    logic [W-1:0] re;
    logic [W-1:0] im;
  } cplx_w_t;

  r4_state_t    state_q, state_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [1:0]   k_q, k_d;
  logic [1:0]   ptr_q, ptr_d;
  logic [3:0]   wait_q, wait_d;
  logic         op_we, cap_we, done_d;
  logic [2:0]   sel_d;
  logic [W-1:0] rd_re, rd_im;
  cplx_w_t      op_q [R4_N];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    ptr_d   = ptr_q;
    wait_d  = wait_q;
    op_we   = 1'b0;
    cap_we  = 1'b0;
    done_d  = 1'b0;
    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
      k_d     = '0;
      ptr_d   = '0;
      wait_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d = LOAD;
            cnt_d   = '0;
          end
        end
        LOAD: begin
          if (in_valid && in_ready) begin
            op_we = 1'b1;
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == LAST_IDX) begin
              k_d     = '0;
              wait_d  = SETTLE_LD;
              state_d = (SETTLE_LD == 4'd0) ? CAPTURE : r4_pkg::SETTLE;
            end
          end
        end
        r4_pkg::SETTLE: begin
          wait_d = (wait_q == 4'd0) ? 4'd0 : wait_q - 4'd1;
          if (wait_q <= 4'd1) state_d = CAPTURE;
        end
        CAPTURE: begin
          cap_we = 1'b1;
          if (k_q != LAST_IDX) begin
            k_d     = k_q + 2'd1;
            wait_d  = SETTLE_LD;
            state_d = (SETTLE_LD == 4'd0) ? CAPTURE : r4_pkg::SETTLE;
          end else begin
            ptr_d   = '0;
            state_d = DRAIN;
          end
        end
        DRAIN: begin
          if (out_valid && out_ready) begin
            ptr_d = ptr_q + 2'd1;
            if (ptr_q == LAST_IDX) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Select is enabled only while the butterfly result is being settled or captured.
  always_comb begin
    sel_d = '0;
    if (state_d == r4_pkg::SETTLE || state_d == CAPTURE) begin
      sel_d[SEL_EN_BIT] = 1'b1;
      sel_d[1:0]        = k_d;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      k_q     <= '0;
      ptr_q   <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      ptr_q   <= ptr_d;
      wait_q  <= wait_d;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < R4_N; i++) begin
        op_q[i] <= '0;
      end
    end else if (op_we) begin
      op_q[cnt_q] <= {in_re, in_im};
    end
  end

  // Every handshake and data output is a flop fed from the next-state decode.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sel       <= '0;
      out_re    <= '0;
      out_im    <= '0;
      out_idx   <= '0;
    end else begin
      in_ready  <= (state_d == LOAD);
      out_valid <= (state_d == DRAIN);
      busy      <= (state_d != IDLE);
      done      <= done_d;
      sel       <= sel_d;
      out_re    <= (state_d == DRAIN) ? rd_re : '0;
      out_im    <= (state_d == DRAIN) ? rd_im : '0;
      out_idx   <= (state_d == DRAIN) ? ptr_d : '0;
    end
  end

  r4_result_buf #(.W(W)) u_result_buf (
    .clk    (wb_clk_i),
    .rst    (wb_rst_i),
    .wr_en  (cap_we),
    .wr_idx (k_q),
    .wr_re  (Xr),
    .wr_im  (Xi),
    .rd_idx (ptr_d),
    .rd_re  (rd_re),
    .rd_im  (rd_im)
  );

  assign xr0 = op_q[0].re;
  assign xr1 = op_q[1].re;
  assign xr2 = op_q[2].re;
  assign xr3 = op_q[3].re;
  assign xi0 = op_q[0].im;
  assign xi1 = op_q[1].im;
  assign xi2 = op_q[2].im;
  assign xi3 = op_q[3].im;

endmodule

// File: tb/tb_r4_butter_seq.sv
// tb/tb_r4_butter_seq.sv - directed bench for r4_butter_seq with settle times 1 and 0
module tb_r4_butter_seq;

  localparam int W = 4;

  typedef struct packed {
    logic [1:0]   idx;
    logic [W-1:0] re;
    logic [W-1:0] im;
  } res_t;

  logic clk = 1'b0, rst = 1'b1;
  logic start = 1'b0, abort = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [W-1:0] in_re = '0, in_im = '0;

  logic         in_ready1, out_valid1, busy1, done1;
  logic [2:0]   sel1;
  logic [W-1:0] xr1 [4], xi1 [4];
  logic [W-1:0] Xr1, Xi1, out_re1, out_im1;
  logic [1:0]   out_idx1;

  logic         in_ready0, out_valid0, busy0, done0;
  logic [2:0]   sel0;
  logic [W-1:0] xr0 [4], xi0 [4];
  logic [W-1:0] Xr0, Xi0, out_re0, out_im0;
  logic [1:0]   out_idx0;

  int   mode = 0;
  int   n_cmp = 0, n_mis = 0;
  int   done1_t, done0_t;
  res_t res1 [$], res0 [$];
  logic [W-1:0] x_re [4], x_im [4], e_re [4], e_im [4];

  always #5 clk = ~clk;

  // Butterfly stand-in: 4-point DFT mod 16, or a stub that echoes the select lines.
  function automatic logic [7:0] bfly(input int m, input logic [15:0] ar, input logic [15:0] ai,
                                      input logic [2:0] s);
    int sr, si, re, im, k;
    logic [3:0] st;
    if (m == 1) begin
      st = {1'b0, s};
      return {st, ~st};
    end
    sr = 0;
    si = 0;
    k  = int'(s[1:0]);
    for (int n = 0; n < 4; n++) begin
      re = int'(ar[n*4 +: 4]);
      im = int'(ai[n*4 +: 4]);
      case ((n * k) % 4)
        0:       begin sr += re; si += im; end
        1:       begin sr += im; si -= re; end
        2:       begin sr -= re; si -= im; end
        default: begin sr -= im; si += re; end
      endcase
    end
    return {4'(sr), 4'(si)};
  endfunction

  always_comb {Xr1, Xi1} = bfly(mode, {xr1[3], xr1[2], xr1[1], xr1[0]}, {xi1[3], xi1[2], xi1[1], xi1[0]}, sel1);
  always_comb {Xr0, Xi0} = bfly(mode, {xr0[3], xr0[2], xr0[1], xr0[0]}, {xi0[3], xi0[2], xi0[1], xi0[0]}, sel0);

  r4_butter_seq #(.W(W), .SETTLE(1)) u_dut (
    .wb_clk_i (clk), .wb_rst_i (rst), .start (start), .abort (abort),
    .in_valid (in_valid), .in_ready (in_ready1), .in_re (in_re), .in_im (in_im),
    .xr0 (xr1[0]), .xr1 (xr1[1]), .xr2 (xr1[2]), .xr3 (xr1[3]),
    .xi0 (xi1[0]), .xi1 (xi1[1]), .xi2 (xi1[2]), .xi3 (xi1[3]),
    .sel (sel1), .Xr (Xr1), .Xi (Xi1),
    .out_valid (out_valid1), .out_ready (out_ready), .out_re (out_re1), .out_im (out_im1),
    .out_idx (out_idx1), .busy (busy1), .done (done1)
  );

  r4_butter_seq #(.W(W), .SETTLE(0)) u_dut0 (
    .wb_clk_i (clk), .wb_rst_i (rst), .start (start), .abort (abort),
    .in_valid (in_valid), .in_ready (in_ready0), .in_re (in_re), .in_im (in_im),
    .xr0 (xr0[0]), .xr1 (xr0[1]), .xr2 (xr0[2]), .xr3 (xr0[3]),
    .xi0 (xi0[0]), .xi1 (xi0[1]), .xi2 (xi0[2]), .xi3 (xi0[3]),
    .sel (sel0), .Xr (Xr0), .Xi (Xi0),
    .out_valid (out_valid0), .out_ready (out_ready), .out_re (out_re0), .out_im (out_im0),
    .out_idx (out_idx0), .busy (busy0), .done (done0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] exp_sel(input int t);
    if (t >= 5 && t <= 12) return {1'b1, 2'((t - 5) / 2)};
    return 3'b000;
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "_in_ready"}, in_ready1, 0);
    check({tag, "_out_valid"}, out_valid1, 0);
    check({tag, "_busy"}, busy1, 0);
    check({tag, "_done"}, done1, 0);
    check({tag, "_sel"}, sel1, 0);
    check({tag, "_out"}, {out_re1, out_im1, out_idx1}, 0);
    check({tag, "_ops"}, {xr1[0], xr1[1], xr1[2], xr1[3], xi1[0], xi1[1], xi1[2], xi1[3]}, 0);
    check({tag, "_s0_busy_sel"}, {busy0, sel0, out_valid0}, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Called just after an edge; cycle t is the period following edge t, start is sampled at edge 1.
  task automatic run_tx(input int gap_lo, input int gap_hi, input int ostall, input int extra_start_t,
                        input int abort_t, input bit chk_sel_en, input int budget);
    int in_n, stall_left;
    bit stalled_once;
    res1.delete();
    res0.delete();
    done1_t = -1;
    done0_t = -1;
    in_n = 0;
    stall_left = 0;
    stalled_once = 1'b0;
    for (int t = 0; t < budget; t++) begin
      if (done1 && done1_t < 0) done1_t = t;
      if (done0 && done0_t < 0) done0_t = t;
      if (chk_sel_en && t <= 20) check($sformatf("sel_t%0d", t), sel1, exp_sel(t));
      if (abort_t >= 0 && t == abort_t + 1) begin
        check("abort_busy", busy1, 0);
        check("abort_sel", sel1, 0);
        check("abort_out_valid", out_valid1, 0);
        check("abort_in_ready", in_ready1, 0);
      end
      start    = (t == 0) || (t == extra_start_t);
      abort    = (t == abort_t);
      in_valid = (in_n < 4) && !(t >= gap_lo && t <= gap_hi);
      in_re    = (in_n < 4) ? x_re[in_n] : '0;
      in_im    = (in_n < 4) ? x_im[in_n] : '0;
      if (ostall > 0 && !stalled_once && out_valid1 && out_idx1 == 2'd1) begin
        stall_left   = ostall;
        stalled_once = 1'b1;
      end
      out_ready = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      if (in_valid && in_ready1) in_n++;
      if (out_valid1 && out_ready) res1.push_back({out_idx1, out_re1, out_im1});
      if (out_valid0 && out_ready) res0.push_back({out_idx0, out_re0, out_im0});
      @(posedge clk);
      #1;
    end
    start     = 1'b0;
    abort     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic check_results(input string tag, input bit use0);
    res_t q [$];
    if (use0) q = res0;
    else q = res1;
    check({tag, "_count"}, q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < q.size()) begin
        check($sformatf("%s_idx%0d", tag, i), q[i].idx, i);
        check($sformatf("%s_re%0d", tag, i), q[i].re, e_re[i]);
        check($sformatf("%s_im%0d", tag, i), q[i].im, e_im[i]);
      end
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Nominal DFT on both settle settings; start during DRAIN of the SETTLE=0 unit is ignored.
    mode = 0;
    x_re = '{4'd1, 4'd2, 4'd3, 4'd4};
    x_im = '{4'd0, 4'd0, 4'd0, 4'd0};
    e_re = '{4'd10, 4'd14, 4'd14, 4'd14};
    e_im = '{4'd0, 4'd2, 4'd0, 4'd14};
    run_tx(99, 99, 0, 12, -1, 1'b0, 22);
    check("nom_done_cycle", done1_t, 17);
    check("s0_done_cycle", done0_t, 13);
    check_results("nom", 1'b0);
    check_results("s0", 1'b1);
    check("nom_idle_after", busy1, 0);
    check("s0_start_in_drain_ignored", busy0, 0);
    check("nom_ops_x3", {xr1[3], xi1[3]}, {4'd4, 4'd0});

    // Select/capture alignment through the echo stub.
    do_reset();
    mode = 1;
    e_re = '{4'd4, 4'd5, 4'd6, 4'd7};
    e_im = '{4'd11, 4'd10, 4'd9, 4'd8};
    run_tx(99, 99, 0, -1, -1, 1'b1, 22);
    check("stub_done_cycle", done1_t, 17);
    check_results("stub", 1'b0);

    // Input gap of two cycles plus a five-cycle output stall at idx1.
    do_reset();
    mode = 0;
    e_re = '{4'd10, 4'd14, 4'd14, 4'd14};
    e_im = '{4'd0, 4'd2, 4'd0, 4'd14};
    run_tx(2, 3, 5, -1, -1, 1'b0, 30);
    check("stall_done_cycle", done1_t, 24);
    check_results("stall", 1'b0);

    // Abort during SETTLE of k=2, then a fresh transform on new data.
    do_reset();
    run_tx(99, 99, 0, -1, 9, 1'b0, 14);
    check("abort_no_results", res1.size(), 0);
    check("abort_no_done", done1_t, -1);
    x_re = '{4'd0, 4'd1, 4'd0, 4'd0};
    x_im = '{4'd1, 4'd0, 4'd0, 4'd0};
    e_re = '{4'd1, 4'd0, 4'd15, 4'd0};
    e_im = '{4'd1, 4'd0, 4'd1, 4'd2};
    run_tx(99, 99, 0, -1, -1, 1'b0, 22);
    check("post_abort_done_cycle", done1_t, 17);
    check_results("post_abort", 1'b0);

    // Asynchronous reset while results are draining.
    do_reset();
    run_tx(99, 99, 0, -1, -1, 1'b0, 15);
    check("pre_reset_out_valid", out_valid1, 1);
    check("pre_reset_ops_nonzero", (xr1[0] != 0 || xi1[0] != 0), 1);
    #1;
    rst = 1'b1;
    #1;
    check_reset("async_reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("post_reset_quiet", {out_valid1, busy1, done1}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
